// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic engine: op codes, FSM states
// and the decode of an op code into per-bit operand conditioning.
package arith_pkg;

    typedef enum logic [2:0] {
        OP_A     = 3'd0,
        OP_INC   = 3'd1,
        OP_ADD   = 3'd2,
        OP_ADDC  = 3'd3,
        OP_ADDNB = 3'd4,
        OP_SUB   = 3'd5,
        OP_NAB   = 3'd6,
        OP_RSUB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic inv_a;
        logic use_b;
        logic inv_b;
        logic c0;
    } op_cfg_t;

    function automatic op_cfg_t op_cfg(input op_e op);
        op_cfg_t cfg;
        cfg = '0;
        case (op)
            OP_A:     cfg = '{inv_a: 1'b0, use_b: 1'b0, inv_b: 1'b0, c0: 1'b0};
            OP_INC:   cfg = '{inv_a: 1'b0, use_b: 1'b0, inv_b: 1'b0, c0: 1'b1};
            OP_ADD:   cfg = '{inv_a: 1'b0, use_b: 1'b1, inv_b: 1'b0, c0: 1'b0};
            OP_ADDC:  cfg = '{inv_a: 1'b0, use_b: 1'b1, inv_b: 1'b0, c0: 1'b1};
            OP_ADDNB: cfg = '{inv_a: 1'b0, use_b: 1'b1, inv_b: 1'b1, c0: 1'b0};
            OP_SUB:   cfg = '{inv_a: 1'b0, use_b: 1'b1, inv_b: 1'b1, c0: 1'b1};
            OP_NAB:   cfg = '{inv_a: 1'b1, use_b: 1'b1, inv_b: 1'b0, c0: 1'b0};
            OP_RSUB:  cfg = '{inv_a: 1'b1, use_b: 1'b1, inv_b: 1'b0, c0: 1'b1};
            default:  cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared with the per-bit arithmetic slice.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_arith_unit.sv
// Bit-serial WIDTH-bit adder/subtractor: operands are shifted LSB-first through one
// full-adder cell with a registered carry; result, carry-out and zero flag are held.
module serial_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Partial result collects WIDTH-1 bits; the final bit goes straight into result_q.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic             inv_a_q, inv_a_d;
    logic             use_b_q, use_b_d;
    logic             inv_b_q, inv_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;

    logic             x_bit, y_bit, sum_bit, co_bit;
    logic [WIDTH-1:0] res_next;
    op_cfg_t          cfg_new;

    assign x_bit    = a_sh_q[0] ^ inv_a_q;
    assign y_bit    = use_b_q & (b_sh_q[0] ^ inv_b_q);
    assign res_next = {sum_bit, res_sh_q};
    assign cfg_new  = op_cfg(op_e'(op));

    full_adder u_fa (
        .a_i  (x_bit),
        .b_i  (y_bit),
        .ci_i (carry_q),
        .s_o  (sum_bit),
        .co_o (co_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            inv_a_q  <= 1'b0;
            use_b_q  <= 1'b0;
            inv_b_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            inv_a_q  <= inv_a_d;
            use_b_q  <= use_b_d;
            inv_b_q  <= inv_b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        inv_a_d  = inv_a_q;
        use_b_d  = use_b_q;
        inv_b_d  = inv_b_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    carry_d  = cfg_new.c0;
                    inv_a_d  = cfg_new.inv_a;
                    use_b_d  = cfg_new.use_b;
                    inv_b_d  = cfg_new.inv_b;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next[WIDTH-1:1];
                carry_d  = co_bit;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    result_d = res_next;
                    cout_d   = co_bit;
                    zero_d   = (res_next == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule
